// File: rtl/reg_scoreboard.sv
// Per-register pending-write scoreboard; issue_ready is combinational, busy_mask/pending_total update one cycle after accept/wb.
// Stalls issue on unforwardable source hazards or a saturated destination counter; flush clears all tracking.
module reg_scoreboard #(
  parameter int NUM_REGS    = 32,
  parameter int ADDR_W      = 5,
  parameter int MAX_PENDING = 3,
  parameter int TOTAL_W     = 7
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                issue_valid,
  input  logic [ADDR_W-1:0]   issue_rs1,
  input  logic [ADDR_W-1:0]   issue_rs2,
  input  logic                issue_use_rs1,
  input  logic                issue_use_rs2,
  input  logic                issue_wen,
  input  logic [ADDR_W-1:0]   issue_rd,
  input  logic [1:0]          issue_fwd_ok,
  output logic                issue_ready,
  input  logic                wb_valid,
  input  logic [ADDR_W-1:0]   wb_rd,
  input  logic                flush,
  output logic [NUM_REGS-1:0] busy_mask,
  output logic [TOTAL_W-1:0]  pending_total,
  output logic                err_underflow
);

  localparam int CNT_W = $clog2(MAX_PENDING + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_PENDING);

  logic [CNT_W-1:0]    cnt     [NUM_REGS];
  logic [CNT_W-1:0]    cnt_nxt [NUM_REGS];
  logic [NUM_REGS-1:0] inc;
  logic [NUM_REGS-1:0] dec;
  logic [NUM_REGS-1:0] busy_nxt;
  logic [TOTAL_W-1:0]  total_nxt;
  logic [CNT_W-1:0]    eff;
  logic [CNT_W-1:0]    eff_rs1;
  logic [CNT_W-1:0]    eff_rs2;
  logic [CNT_W-1:0]    eff_rd;
  logic                uflow_raw;
  logic                hz1;
  logic                hz2;
  logic                sat;
  logic                acc;

  // Lookups start at r=1 so x0 and out-of-range addresses never match and read as idle.
  always_comb begin
    eff       = '0;
    eff_rs1   = '0;
    eff_rs2   = '0;
    eff_rd    = '0;
    dec       = '0;
    uflow_raw = 1'b0;
    for (int r = 1; r < NUM_REGS; r++) begin
      dec[r] = wb_valid && (wb_rd == ADDR_W'(r)) && (cnt[r] != '0);
      if (wb_valid && (wb_rd == ADDR_W'(r)) && (cnt[r] == '0)) uflow_raw = 1'b1;
      eff = cnt[r] - CNT_W'(dec[r]);
      if (issue_rs1 == ADDR_W'(r)) eff_rs1 = eff;
      if (issue_rs2 == ADDR_W'(r)) eff_rs2 = eff;
      if (issue_rd == ADDR_W'(r))  eff_rd  = eff;
    end
  end

  always_comb begin
    hz1         = issue_use_rs1 && (eff_rs1 != '0) && !issue_fwd_ok[0];
    hz2         = issue_use_rs2 && (eff_rs2 != '0) && !issue_fwd_ok[1];
    sat         = issue_wen && (eff_rd == CNT_MAX);
    issue_ready = !flush && !hz1 && !hz2 && !sat;
    acc         = issue_valid && issue_ready;
    inc         = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      inc[r] = acc && issue_wen && (issue_rd == ADDR_W'(r));
    end
    busy_nxt = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      cnt_nxt[r]  = flush ? '0 : cnt[r] + CNT_W'(inc[r]) - CNT_W'(dec[r]);
      busy_nxt[r] = (cnt_nxt[r] != '0);
    end
    // At most one inc and one dec per cycle, so the total tracks with single-step adjustments.
    total_nxt = flush ? '0 : pending_total + TOTAL_W'(|inc) - TOTAL_W'(|dec);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) cnt[r] <= '0;
      busy_mask     <= '0;
      pending_total <= '0;
      err_underflow <= 1'b0;
    end else begin
      cnt           <= cnt_nxt;
      busy_mask     <= busy_nxt;
      pending_total <= total_nxt;
      if (uflow_raw && !flush) err_underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed scoreboard bench: driver queues hand-computed expectations, monitor samples DUT mid-cycle and compares.
module tb_reg_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        issue_valid = 1'b0;
  logic [4:0]  issue_rs1 = '0;
  logic [4:0]  issue_rs2 = '0;
  logic        issue_use_rs1 = 1'b0;
  logic        issue_use_rs2 = 1'b0;
  logic        issue_wen = 1'b0;
  logic [4:0]  issue_rd = '0;
  logic [1:0]  issue_fwd_ok = '0;
  logic        issue_ready;
  logic        wb_valid = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic        flush = 1'b0;
  logic [31:0] busy_mask;
  logic [6:0]  pending_total;
  logic        err_underflow;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       name;
    logic        rdy;
    logic [31:0] busy;
    logic [6:0]  tot;
    logic        err;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  reg_scoreboard dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .issue_use_rs1(issue_use_rs1), .issue_use_rs2(issue_use_rs2),
    .issue_wen(issue_wen), .issue_rd(issue_rd), .issue_fwd_ok(issue_fwd_ok),
    .issue_ready(issue_ready), .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush),
    .busy_mask(busy_mask), .pending_total(pending_total), .err_underflow(err_underflow)
  );

  function automatic void chk(string name, string fld, logic [31:0] act, logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s.%s: got 0x%0h expected 0x%0h", name, fld, act, req);
    end
  endfunction

  // Inputs change at negedge; monitor samples 3 time units later, before the next rising edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      while (q.size() > 0) begin
        e = q.pop_front();
        chk(e.name, "ready", {31'b0, issue_ready},   {31'b0, e.rdy});
        chk(e.name, "busy",  busy_mask,              e.busy);
        chk(e.name, "total", {25'b0, pending_total}, {25'b0, e.tot});
        chk(e.name, "err",   {31'b0, err_underflow}, {31'b0, e.err});
      end
    end
  end

  task automatic step(input string name, input logic v, input logic [4:0] rs1, input logic u1,
                      input logic [4:0] rs2, input logic u2, input logic wen, input logic [4:0] rd,
                      input logic [1:0] fwd, input logic wbv, input logic [4:0] wbr,
                      input logic fl, input logic rn, input logic e_rdy,
                      input logic [31:0] e_busy, input logic [6:0] e_tot, input logic e_err);
    exp_t e;
    @(negedge clk);
    issue_valid = v; issue_rs1 = rs1; issue_use_rs1 = u1; issue_rs2 = rs2; issue_use_rs2 = u2;
    issue_wen = wen; issue_rd = rd; issue_fwd_ok = fwd; wb_valid = wbv; wb_rd = wbr;
    flush = fl; rst_n = rn;
    e.name = name; e.rdy = e_rdy; e.busy = e_busy; e.tot = e_tot; e.err = e_err;
    q.push_back(e);
  endtask

  initial begin
    int budget;
    //    name           v  rs1 u1 rs2 u2 wen rd  fwd  wbv wbr fl rn  rdy busy        tot err
    step("reset",        0, 0,  0, 0,  0, 0,  0,  2'd0, 0, 0,  0, 0,  1,  32'h0,      0,  0);
    step("iss_rd5",      1, 0,  0, 0,  0, 1,  5,  2'd0, 0, 0,  0, 1,  1,  32'h0,      0,  0);
    step("after_rd5",    0, 0,  0, 0,  0, 0,  0,  2'd0, 0, 0,  0, 1,  1,  32'h20,     1,  0);
    step("hz_rs1_5",     1, 5,  1, 0,  0, 0,  0,  2'd0, 0, 0,  0, 1,  0,  32'h20,     1,  0);
    step("fwd_rs1_5",    1, 5,  1, 0,  0, 0,  0,  2'd1, 0, 0,  0, 1,  1,  32'h20,     1,  0);
    step("hz_wb5",       1, 5,  1, 0,  0, 0,  0,  2'd0, 1, 5,  0, 1,  1,  32'h20,     1,  0);
    step("after_wb5",    0, 0,  0, 0,  0, 0,  0,  2'd0, 0, 0,  0, 1,  1,  32'h0,      0,  0);
    step("rd7_a",        1, 0,  0, 0,  0, 1,  7,  2'd0, 0, 0,  0, 1,  1,  32'h0,      0,  0);
    step("rd7_b",        1, 0,  0, 0,  0, 1,  7,  2'd0, 0, 0,  0, 1,  1,  32'h80,     1,  0);
    step("rd7_c",        1, 0,  0, 0,  0, 1,  7,  2'd0, 0, 0,  0, 1,  1,  32'h80,     2,  0);
    step("rd7_sat",      1, 0,  0, 0,  0, 1,  7,  2'd0, 0, 0,  0, 1,  0,  32'h80,     3,  0);
    step("rd7_sat_wb",   1, 0,  0, 0,  0, 1,  7,  2'd0, 1, 7,  0, 1,  1,  32'h80,     3,  0);
    step("hz_rs2_7",     1, 0,  0, 7,  1, 0,  0,  2'd0, 0, 0,  0, 1,  0,  32'h80,     3,  0);
    step("wb7_a",        0, 0,  0, 0,  0, 0,  0,  2'd0, 1, 7,  0, 1,  1,  32'h80,     3,  0);
    step("wb7_b",        0, 0,  0, 0,  0, 0,  0,  2'd0, 1, 7,  0, 1,  1,  32'h80,     2,  0);
    step("wb7_c",        0, 0,  0, 0,  0, 0,  0,  2'd0, 1, 7,  0, 1,  1,  32'h80,     1,  0);
    step("iss_rd3",      1, 0,  0, 0,  0, 1,  3,  2'd0, 0, 0,  0, 1,  1,  32'h0,      0,  0);
    step("iss_rd9_a",    1, 0,  0, 0,  0, 1,  9,  2'd0, 0, 0,  0, 1,  1,  32'h8,      1,  0);
    step("iss_rd9_b",    1, 0,  0, 0,  0, 1,  9,  2'd0, 0, 0,  0, 1,  1,  32'h208,    2,  0);
    step("flush",        1, 0,  0, 0,  0, 1,  4,  2'd0, 1, 3,  1, 1,  0,  32'h208,    3,  0);
    step("after_flush",  0, 0,  0, 0,  0, 0,  0,  2'd0, 0, 0,  0, 1,  1,  32'h0,      0,  0);
    step("x0_issue",     1, 0,  1, 0,  1, 1,  0,  2'd0, 0, 0,  0, 1,  1,  32'h0,      0,  0);
    step("x0_wb",        0, 0,  0, 0,  0, 0,  0,  2'd0, 1, 0,  0, 1,  1,  32'h0,      0,  0);
    step("after_x0",     0, 0,  0, 0,  0, 0,  0,  2'd0, 0, 0,  0, 1,  1,  32'h0,      0,  0);
    step("uflow_wb12",   0, 0,  0, 0,  0, 0,  0,  2'd0, 1, 12, 0, 1,  1,  32'h0,      0,  0);
    step("sticky_rd6_a", 1, 0,  0, 0,  0, 1,  6,  2'd0, 0, 0,  0, 1,  1,  32'h0,      0,  1);
    step("sticky_rd6_b", 1, 0,  0, 0,  0, 1,  6,  2'd0, 0, 0,  0, 1,  1,  32'h40,     1,  1);
    step("cnt6_2",       0, 0,  0, 0,  0, 0,  0,  2'd0, 0, 0,  0, 1,  1,  32'h40,     2,  1);
    step("async_rst",    1, 6,  1, 0,  0, 0,  0,  2'd0, 0, 0,  0, 0,  1,  32'h0,      0,  0);
    step("post_rst",     1, 6,  1, 0,  0, 0,  0,  2'd0, 0, 0,  0, 1,  1,  32'h0,      0,  0);

    budget = 20;
    @(negedge clk);
    while (q.size() > 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
    end
    #4;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
